// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types and constants for the fetch queue slice.
package fetch_queue_pkg;

  // Fetch FSM: no request, one request outstanding, outstanding response to be discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fq_state_e;

  // Instruction size in bytes; fetch addresses step by this amount.
  localparam logic [31:0] INSTR_ALIGN = 32'd4;

  // First fetch address after reset unless the instance overrides it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force an address onto an instruction boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~(INSTR_ALIGN - 32'd1);
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: DEPTH-entry FIFO for {instruction, pc} pairs with a flush input.
// DEPTH must be a power of two so the pointers wrap naturally.
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: pops need data, pushes need room (a same-cycle pop makes room).
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop & (count_r != '0);
    do_push_s = push & (~full_s | do_pop_s);
  end

  // Storage, pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + 1'b1;
      end else if (!do_push_s && do_pop_s) begin
        count_r <= count_r - 1'b1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Head entry and status come straight from registers.
  always_comb begin
    head_data = mem_r[rd_ptr_r];
    count     = count_r;
    empty     = (count_r == '0);
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction fetcher feeding a small FIFO.
// Optional feature macro FETCH_QUEUE_BYPASS_EN: an ack into an empty queue is
// presented to the core in the same cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  fq_state_e     state_r;
  fq_state_e     state_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_s;
  logic          ack_s;
  logic          push_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic [63:0]   head_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   after_idle_s;
  logic [CW:0]   after_wait_s;

  // A redirect voids any same-cycle ack and pop.
  always_comb begin
    ack_s = (state_r == WAIT) & imem_ack & ~redirect;
    pop_s = ~fifo_empty_s & instr_ready & ~redirect;
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_s;

  // Empty queue: show the arriving word now and skip the write if the core takes it.
  always_comb begin
    bypass_s    = ack_s & fifo_empty_s;
    push_s      = ack_s & ~(bypass_s & instr_ready);
    instr_valid = ~fifo_empty_s | bypass_s;
    if (bypass_s) begin
      instr    = imem_rdata;
      instr_pc = fetch_pc_r;
    end else begin
      instr    = head_s[63:32];
      instr_pc = head_s[31:0];
    end
  end
`else
  // Core interface is driven only by the queue head.
  always_comb begin
    push_s      = ack_s;
    instr_valid = ~fifo_empty_s;
    instr       = head_s[63:32];
    instr_pc    = head_s[31:0];
  end
`endif

  // Memory side is a decode of registered state.
  always_comb begin
    imem_req  = (state_r == WAIT);
    imem_addr = fetch_pc_r;
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push_s),
    .push_data ({imem_rdata, fetch_pc_r}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s),
    .empty     (fifo_empty_s)
  );

  // Next state and next fetch PC; room checks use the occupancy after this cycle's pop/push.
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    after_idle_s = {1'b0, count_s} - {{CW{1'b0}}, pop_s};
    after_wait_s = {1'b0, count_s} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};
    case (state_r)
      IDLE: begin
        if (!redirect && (after_idle_s < DEPTH_L)) begin
          state_s = WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_s = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          state_s = (after_wait_s < DEPTH_L) ? WAIT : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (redirect) begin
      fetch_pc_s = align_pc(redirect_pc);
    end else if (ack_s) begin
      fetch_pc_s = fetch_pc_r + INSTR_ALIGN;
    end else begin
      fetch_pc_s = fetch_pc_r;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
    end
  end

endmodule
